// File: rtl/control_sequencer.sv
// control_sequencer: T0-T5 fetch/decode/execute controller driving the 15-bit bus-CPU control word.
// Define CTRL_JUMP_EN to decode opcode 0011 as JMP; otherwise 0011 runs as a NOP.
module control_sequencer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        programming,
    input  logic [3:0]  opcode,
    output logic [14:0] out,
    output logic [2:0]  stage,
    output logic        halted
);
    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        HOLD = 3'd7
    } stage_t;

    localparam logic [14:0] IDLE = 15'h0FE3;
    localparam logic [14:0] C_P  = 15'h4000;
    localparam logic [14:0] E_P  = 15'h2000;
`ifdef CTRL_JUMP_EN
    localparam logic [14:0] L_P  = 15'h1000;
`endif
    localparam logic [14:0] L_MA = 15'h0800;
    localparam logic [14:0] CE   = 15'h0200;
    localparam logic [14:0] L_I  = 15'h0080;
    localparam logic [14:0] E_I  = 15'h0040;
    localparam logic [14:0] L_A  = 15'h0020;
    localparam logic [14:0] E_A  = 15'h0010;
    localparam logic [14:0] S_U  = 15'h0008;
    localparam logic [14:0] E_U  = 15'h0004;
    localparam logic [14:0] L_B  = 15'h0002;
    localparam logic [14:0] L_O  = 15'h0001;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
`ifdef CTRL_JUMP_EN
    localparam logic [3:0] OP_JMP = 4'b0011;
`endif
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    stage_t      r_stage;
    stage_t      w_stage_nxt;
    logic        r_halted;
    logic [3:0]  r_opcode;
    logic [14:0] r_out;
    logic [3:0]  w_op;
    logic [14:0] w_toggle;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stage  <= HOLD;
            r_halted <= 1'b0;
        end else begin
            r_stage <= w_stage_nxt;
            // HLT latches even if the programmer grabs the bus in the same cycle
            if (r_stage == T3 && r_opcode == OP_HLT)
                r_halted <= 1'b1;
        end
    end

    always_comb begin
        w_stage_nxt = HOLD;
        if (!programming && !r_halted) begin
            case (r_stage)
                HOLD:    w_stage_nxt = T0;
                T0:      w_stage_nxt = T1;
                T1:      w_stage_nxt = T2;
                T2:      w_stage_nxt = T3;
                T3:      w_stage_nxt = T4;
                T4:      w_stage_nxt = T5;
                T5:      w_stage_nxt = T0;
                default: w_stage_nxt = HOLD;
            endcase
        end
    end

    // At T3 the opcode is captured on this same negedge, so decode the live IR bits.
    always_comb begin
        w_op     = (r_stage == T3) ? opcode : r_opcode;
        w_toggle = '0;
        case (r_stage)
            T0: w_toggle = E_P | L_MA;
            T1: w_toggle = C_P;
            T2: w_toggle = CE | L_I;
            T3: begin
                case (w_op)
                    OP_LDA, OP_ADD, OP_SUB: w_toggle = E_I | L_MA;
                    OP_OUT:                 w_toggle = E_A | L_O;
`ifdef CTRL_JUMP_EN
                    OP_JMP:                 w_toggle = E_I | L_P;
`endif
                    default:                w_toggle = '0;
                endcase
            end
            T4: begin
                case (w_op)
                    OP_LDA:         w_toggle = CE | L_A;
                    OP_ADD, OP_SUB: w_toggle = CE | L_B;
                    default:        w_toggle = '0;
                endcase
            end
            T5: begin
                case (w_op)
                    OP_ADD:  w_toggle = E_U | L_A;
                    OP_SUB:  w_toggle = E_U | L_A | S_U;
                    default: w_toggle = '0;
                endcase
            end
            default: w_toggle = '0;
        endcase
    end

    always_ff @(negedge clk) begin
        if (!resetn) begin
            r_out    <= IDLE;
            r_opcode <= 4'b0000;
        end else begin
            r_out <= IDLE ^ w_toggle;
            if (r_stage == T3)
                r_opcode <= opcode;
        end
    end

    assign out    = r_out;
    assign stage  = r_stage;
    assign halted = r_halted;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, multi-cycle corner sequences, random run vs instruction-level model.
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        resetn;
    logic        programming;
    logic [3:0]  opcode;
    logic [14:0] out;
    logic [2:0]  stage;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_stage = 7;
    logic        m_halted = 1'b0;
    logic [3:0]  m_lat = 4'h0;
    logic [14:0] m_word = 15'h0FE3;

    typedef struct {
        logic        r;
        logic        p;
        logic [3:0]  op;
        logic [2:0]  st;
        logic [14:0] w;
        logic        h;
    } vec_t;
    vec_t tbl[$];

    control_sequencer dut (
        .clk         (clk),
        .resetn      (resetn),
        .programming (programming),
        .opcode      (opcode),
        .out         (out),
        .stage       (stage),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Control words per instruction and stage, taken straight from the documented micro-program.
    function automatic logic [14:0] m_expected(input int st, input logic [3:0] op);
        logic [14:0] w;
        w = 15'h0FE3;
        case (st)
            0: w = 15'h27E3;
            1: w = 15'h4FE3;
            2: w = 15'h0D63;
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) w = 15'h07A3;
                else if (op == 4'hE) w = 15'h0FF2;
`ifdef CTRL_JUMP_EN
                else if (op == 4'h3) w = 15'h1FA3;
`endif
            end
            4: begin
                if (op == 4'h0) w = 15'h0DC3;
                else if (op == 4'h1 || op == 4'h2) w = 15'h0DE1;
            end
            5: begin
                if (op == 4'h1) w = 15'h0FC7;
                else if (op == 4'h2) w = 15'h0FCF;
            end
            default: w = 15'h0FE3;
        endcase
        return w;
    endfunction

    // One clock: drive inputs, check stage/halted after posedge and out after negedge against the model.
    task automatic step(input logic r, input logic p, input logic [3:0] op);
        logic nh;
        resetn = r; programming = p; opcode = op;
        @(posedge clk);
        if (!r) begin
            m_stage = 7; m_halted = 1'b0; m_lat = 4'h0;
        end else begin
            nh = m_halted || (m_stage == 3 && m_lat == 4'hF);
            if (p || m_halted) m_stage = 7;
            else if (m_stage == 7) m_stage = 0;
            else m_stage = (m_stage + 1) % 6;
            m_halted = nh;
        end
        #1;
        chk("model_stage", 32'(stage), 32'(m_stage));
        chk("model_halted", 32'(halted), 32'(m_halted));
        @(negedge clk);
        if (!r) begin
            m_word = 15'h0FE3; m_lat = 4'h0;
        end else begin
            if (m_stage == 3) m_lat = op;
            m_word = m_expected(m_stage, m_lat);
        end
        #1;
        chk("model_out", 32'(out), 32'(m_word));
    endtask

    task automatic add(input logic r, input logic p, input logic [3:0] op,
                       input logic [2:0] st, input logic [14:0] w, input logic h);
        vec_t v;
        v.r = r; v.p = p; v.op = op; v.st = st; v.w = w; v.h = h;
        tbl.push_back(v);
    endtask

    task automatic add_instr(input logic [3:0] op, input logic [14:0] w3,
                             input logic [14:0] w4, input logic [14:0] w5);
        add(1, 0, op, 3'd0, 15'h27E3, 0);
        add(1, 0, op, 3'd1, 15'h4FE3, 0);
        add(1, 0, op, 3'd2, 15'h0D63, 0);
        add(1, 0, op, 3'd3, w3, 0);
        add(1, 0, op, 3'd4, w4, 0);
        add(1, 0, op, 3'd5, w5, 0);
    endtask

    task automatic step_chk(input string nm, input logic r, input logic p, input logic [3:0] op,
                            input logic [2:0] st, input logic [14:0] w, input logic h);
        step(r, p, op);
        chk({nm, "_stage"}, 32'(stage), 32'(st));
        chk({nm, "_out"}, 32'(out), 32'(w));
        chk({nm, "_halted"}, 32'(halted), 32'(h));
    endtask

    initial begin
        logic [14:0] jmp_t3;
        logic        rp;
`ifdef CTRL_JUMP_EN
        jmp_t3 = 15'h1FA3;
`else
        jmp_t3 = 15'h0FE3;
`endif
        resetn = 1'b0; programming = 1'b1; opcode = 4'h0;

        // Reset together with programming, then LDA/ADD/SUB/OUT/0011/HLT back to back.
        add(0, 1, 4'h0, 3'd7, 15'h0FE3, 0);
        add_instr(4'h0, 15'h07A3, 15'h0DC3, 15'h0FE3);
        add_instr(4'h1, 15'h07A3, 15'h0DE1, 15'h0FC7);
        add_instr(4'h2, 15'h07A3, 15'h0DE1, 15'h0FCF);
        add_instr(4'hE, 15'h0FF2, 15'h0FE3, 15'h0FE3);
        add_instr(4'h3, jmp_t3,   15'h0FE3, 15'h0FE3);
        add(1, 0, 4'hF, 3'd0, 15'h27E3, 0);
        add(1, 0, 4'hF, 3'd1, 15'h4FE3, 0);
        add(1, 0, 4'hF, 3'd2, 15'h0D63, 0);
        add(1, 0, 4'hF, 3'd3, 15'h0FE3, 0);
        add(1, 0, 4'hF, 3'd4, 15'h0FE3, 1);
        add(1, 0, 4'hF, 3'd7, 15'h0FE3, 1);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].p, tbl[i].op);
            chk($sformatf("vec%0d_stage", i), 32'(stage), 32'(tbl[i].st));
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].w));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(tbl[i].h));
        end

        // Halted sequencer ignores programming toggles; only reset releases it.
        for (int i = 0; i < 20; i++) begin
            rp = i[0];
            step_chk("halt_hold", 1, rp, 4'($urandom_range(0, 15)), 3'd7, 15'h0FE3, 1);
        end
        step_chk("halt_reset", 0, 0, 4'h0, 3'd7, 15'h0FE3, 0);
        step_chk("halt_release", 1, 0, 4'h1, 3'd0, 15'h27E3, 0);

        // Programmer grabs the bus during T4 of an ADD.
        step_chk("abort_t1", 1, 0, 4'h1, 3'd1, 15'h4FE3, 0);
        step_chk("abort_t2", 1, 0, 4'h1, 3'd2, 15'h0D63, 0);
        step_chk("abort_t3", 1, 0, 4'h1, 3'd3, 15'h07A3, 0);
        step_chk("abort_t4", 1, 0, 4'h1, 3'd4, 15'h0DE1, 0);
        step_chk("abort_hold", 1, 1, 4'h1, 3'd7, 15'h0FE3, 0);
        step_chk("abort_hold2", 1, 1, 4'h1, 3'd7, 15'h0FE3, 0);
        step_chk("abort_restart", 1, 0, 4'h0, 3'd0, 15'h27E3, 0);

        // One-clock reset in the middle of T2.
        step_chk("rst_t1", 1, 0, 4'h0, 3'd1, 15'h4FE3, 0);
        step_chk("rst_t2", 1, 0, 4'h0, 3'd2, 15'h0D63, 0);
        step_chk("rst_pulse", 0, 0, 4'h0, 3'd7, 15'h0FE3, 0);
        step_chk("rst_restart", 1, 0, 4'hF, 3'd0, 15'h27E3, 0);

        // HLT with programming raised at the same T3.
        step_chk("hltp_t1", 1, 0, 4'hF, 3'd1, 15'h4FE3, 0);
        step_chk("hltp_t2", 1, 0, 4'hF, 3'd2, 15'h0D63, 0);
        step_chk("hltp_t3", 1, 0, 4'hF, 3'd3, 15'h0FE3, 0);
        step_chk("hltp_prog", 1, 1, 4'hF, 3'd7, 15'h0FE3, 1);
        step_chk("hltp_stay", 1, 0, 4'h0, 3'd7, 15'h0FE3, 1);
        step_chk("hltp_reset", 0, 0, 4'h0, 3'd7, 15'h0FE3, 0);

        // Random run: resets, programming bursts and arbitrary opcodes against the model.
        rp = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) rp = ~rp;
            step(($urandom_range(0, 24) != 0), rp, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
